// File: rtl/snd_pkg.sv
// Shared types for the audio sample-stream path: stereo frame layout,
// stream controller states and source indices.
package snd_pkg;

  // Packed so that a raw 32-bit producer word maps directly onto {L, R}.
  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } snd_frame_t;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_RUN   = 2'd1,
    DS_DRAIN = 2'd2
  } ds_state_t;

  // Bit positions of each source in the one-hot grant vector.
  localparam int SRC0 = 0;
  localparam int SRC1 = 1;

  // Split a producer word into its stereo halves; no arithmetic applied.
  function automatic snd_frame_t to_frame(input logic [31:0] data);
    return snd_frame_t'(data);
  endfunction

endpackage

// File: rtl/dac_stream_ctrl_if.sv
// Producer-side handshake bundle: two sources, each with a level request,
// a valid/ready frame channel and a 32-bit {L, R} frame.
interface dac_stream_ctrl_if;

  logic        s0_req;
  logic        s0_valid;
  logic [31:0] s0_data;
  logic        s0_ready;

  logic        s1_req;
  logic        s1_valid;
  logic [31:0] s1_data;
  logic        s1_ready;

  // Producers drive requests and frames, and observe ready.
  modport master (
    output s0_req, s0_valid, s0_data, s1_req, s1_valid, s1_data,
    input  s0_ready, s1_ready
  );

  // The stream controller consumes frames and drives ready.
  modport slave (
    input  s0_req, s0_valid, s0_data, s1_req, s1_valid, s1_data,
    output s0_ready, s1_ready
  );

endinterface

// File: rtl/snd_fifo.sv
// Single-clock stereo frame FIFO. Occupancy is tracked by an explicit level
// counter, so full/empty never depend on pointer comparison; pointers wrap
// modulo DEPTH. Flush discards contents and wins over push and pop.
module snd_fifo
  import snd_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  snd_frame_t push_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output snd_frame_t rd_data_o,
  output logic [AW:0] level_o,
  output logic       full_o,
  output logic       empty_o
);

  snd_frame_t        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       level_q;
  logic              do_push;
  logic              do_pop;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign do_push   = push_i && !full_o && !flush_i;
  assign do_pop    = pop_i && !empty_o && !flush_i;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Frame storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the level counter alone decides
    // which entries are meaningful, so stale contents are never observed.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/dac_stream_ctrl.sv
// Stream scheduler in front of the DAC: arbitrates two producers into one
// frame FIFO (src0 high priority and never preempted), drains one frame per
// next_sample strobe, counts underruns and raises a half-empty data request.
module dac_stream_ctrl
  import snd_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH),
  parameter int UR_MAX = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               next_sample,
  input  logic               flush,
  input  logic               ur_clr,
  dac_stream_ctrl_if.slave   src,
  output logic [1:0]         grant,
  output logic signed [15:0] snd_l,
  output logic signed [15:0] snd_r,
  output logic               snd_on,
  output logic [AW:0]        level,
  output logic               need_data,
  output logic [7:0]         ur_cnt
);

  ds_state_t  state_q;
  logic [1:0] grant_q;
  logic       snd_on_q;
  snd_frame_t snd_q;
  logic [7:0] ur_cnt_q;
  logic [7:0] ur_cnt_d;

  snd_frame_t fifo_rd;
  snd_frame_t push_frame;
  logic       fifo_full;
  logic       fifo_empty;
  logic       do_push;
  logic       do_pop;
  logic       underrun;

  // Ready depends only on registered state and registered fullness, so a pop
  // in the same cycle can never combinationally re-open a full FIFO.
  assign src.s0_ready = (state_q == DS_RUN) && grant_q[SRC0] && !fifo_full;
  assign src.s1_ready = (state_q == DS_RUN) && grant_q[SRC1] && !fifo_full;

  assign do_push    = (src.s0_valid && src.s0_ready) || (src.s1_valid && src.s1_ready);
  assign push_frame = to_frame(grant_q[SRC0] ? src.s0_data : src.s1_data);
  assign do_pop     = next_sample && !flush && (state_q != DS_IDLE) && !fifo_empty;
  assign underrun   = next_sample && !flush && (state_q == DS_RUN) && fifo_empty;

  snd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (do_push),
    .push_data_i (push_frame),
    .pop_i       (do_pop),
    .flush_i     (flush),
    .rd_data_o   (fifo_rd),
    .level_o     (level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Ownership FSM: grant, preemption of src1 by src0, drain to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DS_IDLE;
      grant_q  <= '0;
      snd_on_q <= 1'b0;
    end else if (flush) begin
      state_q  <= DS_IDLE;
      grant_q  <= '0;
      snd_on_q <= 1'b0;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (src.s0_req) begin
            state_q  <= DS_RUN;
            grant_q  <= 2'b01;
            snd_on_q <= 1'b1;
          end else if (src.s1_req) begin
            state_q  <= DS_RUN;
            grant_q  <= 2'b10;
            snd_on_q <= 1'b1;
          end
        end
        DS_RUN: begin
          if (grant_q[SRC0] ? !src.s0_req : (!src.s1_req || src.s0_req))
            state_q <= DS_DRAIN;
        end
        DS_DRAIN: begin
          if (next_sample && fifo_empty) begin
            state_q  <= DS_IDLE;
            grant_q  <= '0;
            snd_on_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= DS_IDLE;
          grant_q  <= '0;
          snd_on_q <= 1'b0;
        end
      endcase
    end
  end

  // Output sample register: loads the popped frame, holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      snd_q <= '0;
    else if (do_pop) snd_q <= fifo_rd;
  end

  // Next underrun count: clear has priority but still records a coincident underrun.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    ur_cnt_d = ur_cnt_q;
    if (ur_clr)
      ur_cnt_d = underrun ? 8'd1 : 8'd0;
    else if (underrun && (ur_cnt_q != 8'(UR_MAX)))
      ur_cnt_d = ur_cnt_q + 8'd1;
  end

  // Underrun counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ur_cnt_q <= '0;
    else        ur_cnt_q <= ur_cnt_d;
  end

  assign grant     = grant_q;
  assign snd_on    = snd_on_q;
  assign snd_l     = snd_q.l;
  assign snd_r     = snd_q.r;
  assign ur_cnt    = ur_cnt_q;
  assign need_data = (state_q == DS_RUN) && (level <= (AW+1)'(DEPTH / 2));

endmodule

// File: doc/dac_stream_ctrl.md
Name: dac_stream_ctrl

Overview:
- Sample-stream scheduler in front of the audio output path.
- Two producers share one stereo sample FIFO: src0 is high-priority (e.g. CD-DA), src1 is low-priority (e.g. host/MCU stream).
- The FIFO is drained one frame per DAC next_sample strobe; the block drives the DacIn-side sample and snd_on fields.
- Handles grant/preemption, drain, underrun, and data-request watermark.

Parameters:
- DEPTH, 64, FIFO depth in stereo frames; must be a power of 2, minimum 4.
- AW, $clog2(DEPTH), FIFO address width.
- UR_MAX, 255, saturation value of the underrun counter (8-bit).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- next_sample  in  1  one-cycle strobe from DAC sequencer (dsc.next_sample)
- flush  in  1  synchronous abort: empty FIFO, return to IDLE
- s0_req  in  1  src0 requests stream ownership (level)
- s0_valid  in  1  src0 frame valid
- s0_data  in  32  src0 frame {L[31:16], R[15:0]}, signed
- s0_ready  out  1  src0 frame accepted when valid&ready
- s1_req, s1_valid, s1_data, s1_ready  as s0
- grant  out  2  one-hot current owner, 0 when none
- snd_l  out  16  signed left sample to DAC path
- snd_r  out  16  signed right sample to DAC path
- snd_on  out  1  stream active (feeds dac.snd_on)
- level  out  AW+1  FIFO occupancy, 0..DEPTH
- need_data  out  1  level <= DEPTH/2 and state RUN
- ur_cnt  out  8  saturating underrun count
- ur_clr  in  1  clears ur_cnt

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO pointers 0; grant=0; snd_l=snd_r=0; snd_on=0; s*_ready=0; level=0; need_data=0; ur_cnt=0. Reset mid-stream discards FIFO contents immediately.
- FSM states: IDLE, RUN, DRAIN. All transitions registered.
- IDLE:
  - s0_req -> RUN, grant=01.
  - Otherwise s1_req -> RUN, grant=10.
  - src0 wins if both request in the same cycle.
- RUN:
  - Only the owner sees ready = !full; the other source's ready = 0.
  - Owner req low -> DRAIN.
  - Owner src1 and s0_req high -> DRAIN (preemption).
  - src0 is never preempted.
- DRAIN:
  - Both ready=0; grant held; pops continue.
  - next_sample with level==0 -> IDLE, grant=0.
- snd_on = 1 in RUN and DRAIN, 0 in IDLE; registered with state.
- Push: occurs on valid&ready.
- Pop: on next_sample when state!=IDLE and level!=0. snd_l/snd_r update in the cycle after the strobe (1-cycle latency) and hold between strobes.
- Simultaneous push and pop: level unchanged; a full FIFO may pop and accept in the same cycle only if ready was already asserted (ready from registered full; no combinational pop->ready path).
- Underrun:
  - Condition: next_sample in RUN with level==0.
  - snd_l/r hold the last value; ur_cnt+1, saturating at UR_MAX.
  - Empty in DRAIN is not an underrun.
- ur_clr and an underrun in the same cycle: ur_cnt = 1.
- flush: level=0, pointers reset, state IDLE, grant=0, snd_on=0 next cycle; snd_l/r hold.
- flush and next_sample in the same cycle: flush wins, no pop, no underrun.
- Pointer wrap: AW-bit pointers wrap modulo DEPTH; full/empty decided by level, not pointer compare.
- Frame split: L = data[31:16], R = data[15:0]; no arithmetic applied.

Decomposition:
- Shared package snd_pkg:
  - typedef struct packed {logic signed [15:0] l, r;} snd_frame_t
  - enum ds_state_t {DS_IDLE, DS_RUN, DS_DRAIN}
  - localparam SRC0=0, SRC1=1
- Sub-module snd_fifo: synchronous single-clock FIFO of snd_frame_t with push/pop/flush, level, full, empty; async active-low reset.
- The controller FSM, arbiter and underrun logic stay in dac_stream_ctrl.

Test Plan:
- Reset, s1_req=1, push frames 0x0001_FFFF..0x0004_FFFC, four strobes -> grant=10; snd_l=1,2,3,4 and snd_r=-1..-4, each one cycle after its strobe; level 4->0.
- src1 owns with 10 frames queued, assert s0_req -> s1_ready=0 next cycle; DRAIN for 10 strobes; IDLE on the 11th strobe; then RUN with grant=01.
- RUN, FIFO empty, 3 strobes -> ur_cnt=3; snd holds last value; snd_on stays 1. Then 300 more strobes -> ur_cnt=255. ur_clr -> 0.
- Push DEPTH frames without strobes -> level=64, s0_ready=0, need_data=0. One strobe -> level=63, ready reasserts. Pop to 32 -> need_data=1.
- flush coincident with next_sample at level 5 -> level=0, no pop, ur_cnt unchanged, IDLE.
- rst_n low mid-stream (level 20) -> all outputs zero immediately. After release with no req -> remains IDLE.
